// File: rtl/ram_dist_pkg.sv
// Shared types and default sizing for the distributed scan store.
// The optional max tracking is enabled with RAM_DIST_SCAN_MAX_EN.
package ram_dist_pkg;

  localparam int unsigned RAM_DIST_WIDTH = 13;
  localparam int unsigned RAM_DIST_DEPTH = 6;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } scan_state_e;

endpackage

// File: rtl/ram_dist_minscan.sv
// Sequential min (and optionally max, RAM_DIST_SCAN_MAX_EN) scanner over the flattened store.
// Visits one entry per cycle, then publishes registered results with a one-cycle done pulse.
module ram_dist_minscan
  import ram_dist_pkg::*;
#(
  parameter int unsigned WIDTH  = RAM_DIST_WIDTH,
  parameter int unsigned DEPTH  = RAM_DIST_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [DEPTH*WIDTH-1:0] q,
  input  logic [DEPTH-1:0]       valid,
  input  logic                   scan_start,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic [WIDTH-1:0]       min_value,
  output logic [ADDR_W-1:0]      min_index,
  output logic                   none_valid
`ifdef RAM_DIST_SCAN_MAX_EN
  ,
  output logic [WIDTH-1:0]       max_value,
  output logic [ADDR_W-1:0]      max_index
`endif
);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  run_min_q, run_min_d;
  logic [ADDR_W-1:0] run_min_idx_q, run_min_idx_d;
  logic              found_q, found_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  min_value_q, min_value_d;
  logic [ADDR_W-1:0] min_index_q, min_index_d;
  logic              none_valid_q, none_valid_d;
  logic [WIDTH-1:0]  cur_val;
  logic              cur_vld;
`ifdef RAM_DIST_SCAN_MAX_EN
  logic [WIDTH-1:0]  run_max_q, run_max_d;
  logic [ADDR_W-1:0] run_max_idx_q, run_max_idx_d;
  logic [WIDTH-1:0]  max_value_q, max_value_d;
  logic [ADDR_W-1:0] max_index_q, max_index_d;
`endif

  // Entry mux: selects the entry under the scan pointer.
  always_comb begin
    cur_val = '0;
    cur_vld = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx_q == ADDR_W'(i)) begin
        cur_val = q[i*WIDTH +: WIDTH];
        cur_vld = valid[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    run_min_d     = run_min_q;
    run_min_idx_d = run_min_idx_q;
    found_d       = found_q;
    done_d        = 1'b0;
    min_value_d   = min_value_q;
    min_index_d   = min_index_q;
    none_valid_d  = none_valid_q;
`ifdef RAM_DIST_SCAN_MAX_EN
    run_max_d     = run_max_q;
    run_max_idx_d = run_max_idx_q;
    max_value_d   = max_value_q;
    max_index_d   = max_index_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (scan_start) begin
          state_d       = StScan;
          idx_d         = '0;
          run_min_d     = '1;
          run_min_idx_d = '0;
          found_d       = 1'b0;
`ifdef RAM_DIST_SCAN_MAX_EN
          run_max_d     = '0;
          run_max_idx_d = '0;
`endif
        end
      end
      StScan: begin
        // Strict compares keep the lowest index on ties.
        if (cur_vld && (!found_q || cur_val < run_min_q)) begin
          run_min_d     = cur_val;
          run_min_idx_d = idx_q;
        end
`ifdef RAM_DIST_SCAN_MAX_EN
        if (cur_vld && (!found_q || cur_val > run_max_q)) begin
          run_max_d     = cur_val;
          run_max_idx_d = idx_q;
        end
`endif
        if (cur_vld) found_d = 1'b1;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) state_d = StDone;
      end
      StDone: begin
        min_value_d  = run_min_q;
        min_index_d  = run_min_idx_q;
        none_valid_d = ~found_q;
`ifdef RAM_DIST_SCAN_MAX_EN
        max_value_d  = run_max_q;
        max_index_d  = run_max_idx_q;
`endif
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      run_min_q     <= '1;
      run_min_idx_q <= '0;
      found_q       <= 1'b0;
      done_q        <= 1'b0;
      min_value_q   <= '1;
      min_index_q   <= '0;
      none_valid_q  <= 1'b0;
`ifdef RAM_DIST_SCAN_MAX_EN
      run_max_q     <= '0;
      run_max_idx_q <= '0;
      max_value_q   <= '0;
      max_index_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      run_min_q     <= run_min_d;
      run_min_idx_q <= run_min_idx_d;
      found_q       <= found_d;
      done_q        <= done_d;
      min_value_q   <= min_value_d;
      min_index_q   <= min_index_d;
      none_valid_q  <= none_valid_d;
`ifdef RAM_DIST_SCAN_MAX_EN
      run_max_q     <= run_max_d;
      run_max_idx_q <= run_max_idx_d;
      max_value_q   <= max_value_d;
      max_index_q   <= max_index_d;
`endif
    end
  end

  assign scan_busy  = (state_q == StScan);
  assign scan_done  = done_q;
  assign min_value  = min_value_q;
  assign min_index  = min_index_q;
  assign none_valid = none_valid_q;
`ifdef RAM_DIST_SCAN_MAX_EN
  assign max_value  = max_value_q;
  assign max_index  = max_index_q;
`endif

endmodule

// File: rtl/ram_dist_scan.sv
// Parametrised distributed register store with per-entry valid bits and a sequential min scanner.
// Define RAM_DIST_SCAN_MAX_EN to also expose max_value/max_index from the same scan pass.
module ram_dist_scan
  import ram_dist_pkg::*;
#(
  parameter int unsigned WIDTH = RAM_DIST_WIDTH,
  parameter int unsigned DEPTH = RAM_DIST_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WIDTH-1:0]       data,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic [DEPTH-1:0]       valid,
  output logic                   all_valid,
  output logic                   wr_drop,
  input  logic                   scan_start,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic [WIDTH-1:0]       min_value,
  output logic [ADDR_W-1:0]      min_index,
  output logic                   none_valid
`ifdef RAM_DIST_SCAN_MAX_EN
  ,
  output logic [WIDTH-1:0]       max_value,
  output logic [ADDR_W-1:0]      max_index
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             wr_drop_q, wr_drop_d;
  logic             wr_ok;

  // Writes are frozen during a scan so the pass sees a stable snapshot.
  always_comb begin
    wr_ok     = we && (32'(addr) < DEPTH) && !scan_busy;
    wr_drop_d = we && !wr_ok;
    mem_d     = mem_q;
    valid_d   = valid_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ok && addr == ADDR_W'(i)) begin
        mem_d[i]   = data;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      mem_q     <= '{default: '0};
      valid_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q[g*WIDTH +: WIDTH] = mem_q[g];
  end

  assign valid     = valid_q;
  assign all_valid = &valid_q;
  assign wr_drop   = wr_drop_q;

  ram_dist_minscan #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_minscan (
    .clk       (clk),
    .clear     (clear),
    .q         (q),
    .valid     (valid_q),
    .scan_start(scan_start),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .min_value (min_value),
    .min_index (min_index),
    .none_valid(none_valid)
`ifdef RAM_DIST_SCAN_MAX_EN
    ,
    .max_value (max_value),
    .max_index (max_index)
`endif
  );

endmodule

// File: tb/tb_ram_dist_scan.sv
// Scoreboard bench for ram_dist_scan: stimulus pushes expected scan results, a monitor
// pops and compares them on every scan_done pulse.
module tb_ram_dist_scan;

  localparam int unsigned W  = 13;
  localparam int unsigned D  = 6;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          clear, we, scan_start;
  logic [AW-1:0] addr;
  logic [W-1:0]  data;
  logic [D*W-1:0] q;
  logic [D-1:0]  valid;
  logic          all_valid, wr_drop, scan_busy, scan_done, none_valid;
  logic [W-1:0]  min_value;
  logic [AW-1:0] min_index;
`ifdef RAM_DIST_SCAN_MAX_EN
  logic [W-1:0]  max_value;
  logic [AW-1:0] max_index;
`endif

  ram_dist_scan dut (
    .clk       (clk),
    .clear     (clear),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .q         (q),
    .valid     (valid),
    .all_valid (all_valid),
    .wr_drop   (wr_drop),
    .scan_start(scan_start),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .min_value (min_value),
    .min_index (min_index),
    .none_valid(none_valid)
`ifdef RAM_DIST_SCAN_MAX_EN
    ,
    .max_value (max_value),
    .max_index (max_index)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0]  mn;
    logic [AW-1:0] mi;
    logic          nv;
    logic [W-1:0]  mx;
    logic [AW-1:0] xi;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  exp_t e_end;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] entry(input int i);
    return q[i*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
    we   = 1'b1;
    addr = a;
    data = d;
    tick();
    we = 1'b0;
  endtask

  // Push the expected result, then pulse scan_start for one edge.
  task automatic scan_begin(input logic [W-1:0] mn, input logic [AW-1:0] mi, input logic nv,
                            input logic [W-1:0] mx, input logic [AW-1:0] xi);
    exp_t e;
    e.mn  = mn;
    e.mi  = mi;
    e.nv  = nv;
    e.mx  = mx;
    e.xi  = xi;
    e.cyc = cyc + D + 2;
    sb.push_back(e);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  task automatic scan_wait();
    repeat (D + 3) tick();
  endtask

  always @(negedge clk) begin
    if (scan_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_scan_done: got pulse at cycle %0d, required none", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("done_cycle", cyc, e_mon.cyc);
        chk("min_value", 32'(min_value), 32'(e_mon.mn));
        chk("min_index", 32'(min_index), 32'(e_mon.mi));
        chk("none_valid", 32'(none_valid), 32'(e_mon.nv));
`ifdef RAM_DIST_SCAN_MAX_EN
        chk("max_value", 32'(max_value), 32'(e_mon.mx));
        chk("max_index", 32'(max_index), 32'(e_mon.xi));
`endif
      end
    end
  end

  initial begin
    clear      = 1'b1;
    we         = 1'b0;
    scan_start = 1'b0;
    addr       = '0;
    data       = '0;
    tick();
    tick();
    clear = 1'b0;

    // Reset state.
    chk("rst_valid", 32'(valid), 0);
    chk("rst_all_valid", 32'(all_valid), 0);
    chk("rst_min_value", 32'(min_value), 32'h1fff);
    chk("rst_min_index", 32'(min_index), 0);
    chk("rst_none_valid", 32'(none_valid), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_wr_drop", 32'(wr_drop), 0);

    // Empty scan.
    scan_begin(13'h1fff, 3'd0, 1'b1, 13'd0, 3'd0);
    chk("busy_in_scan", 32'(scan_busy), 1);
    scan_wait();

    // Full store.
    write(3'd0, 13'd100);
    write(3'd1, 13'd40);
    write(3'd2, 13'd250);
    write(3'd3, 13'd40);
    write(3'd4, 13'd7);
    chk("all_valid_partial", 32'(all_valid), 0);
    write(3'd5, 13'd900);
    chk("all_valid_full", 32'(all_valid), 1);
    chk("valid_full", 32'(valid), 32'h3f);
    chk("q_entry5", 32'(entry(5)), 900);
    chk("q_entry2", 32'(entry(2)), 250);
    scan_begin(13'd7, 3'd4, 1'b0, 13'd900, 3'd5);
    scan_wait();

    // Tie rule, and result hold across a write.
    write(3'd4, 13'd500);
    chk("hold_min_value", 32'(min_value), 7);
    chk("q_entry4", 32'(entry(4)), 500);
    scan_begin(13'd40, 3'd1, 1'b0, 13'd900, 3'd5);
    scan_wait();

    // Single valid entry.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    write(3'd2, 13'd55);
    chk("single_valid", 32'(valid), 32'h04);
    scan_begin(13'd55, 3'd2, 1'b0, 13'd55, 3'd2);
    // Write on the cycle after scan_start is dropped.
    write(3'd3, 13'd123);
    chk("drop_busy", 32'(wr_drop), 1);
    scan_wait();
    chk("drop_valid3", 32'(valid[3]), 0);
    chk("drop_entry3", 32'(entry(3)), 0);

    // Out-of-range address.
    write(3'd6, 13'd77);
    chk("drop_addr6", 32'(wr_drop), 1);
    chk("drop_addr6_valid", 32'(valid), 32'h04);
    tick();
    chk("drop_pulse_end", 32'(wr_drop), 0);

    // Same-cycle write and scan_start.
    we   = 1'b1;
    addr = 3'd0;
    data = 13'd3;
    scan_begin(13'd3, 3'd0, 1'b0, 13'd55, 3'd2);
    we = 1'b0;
    chk("same_cycle_no_drop", 32'(wr_drop), 0);
    scan_wait();

    // Clear mid-scan aborts without a done pulse.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", 32'(scan_busy), 0);
    chk("abort_min_value", 32'(min_value), 32'h1fff);
    chk("abort_min_index", 32'(min_index), 0);
    chk("abort_none_valid", 32'(none_valid), 0);
    chk("abort_valid", 32'(valid), 0);
    repeat (D + 2) tick();
    scan_begin(13'h1fff, 3'd0, 1'b1, 13'd0, 3'd0);
    scan_wait();

    while (sb.size() > 0) begin
      e_end = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_scan_done: got none, required pulse at cycle %0d", e_end.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_dist_scan.md
Name: ram_dist_scan

Overview:
- Parametrised successor to the 6x13-bit distributed register store used for per-face measurement values.
- Holds DEPTH entries of WIDTH bits, with all entries read out in parallel and a valid bit per entry.
- A sequential scanner finds the minimum valid entry and its index, so the controller FSM can pick the nearest or smallest reading without a combinational compare tree.

Parameters:
- WIDTH, 13, bit width of each stored value.
- DEPTH, 6, number of entries; must be >= 2.
- ADDR_W, $clog2(DEPTH), address width; localparam derived from DEPTH, not overridable.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- clear  input  1  reset, synchronous and active-high.
- we  input  1  write enable, sampled on the clk edge.
- addr  input  ADDR_W  write address.
- data  input  WIDTH  write data.
- q  output  DEPTH*WIDTH  all entries, flattened; entry i is at q[i*WIDTH +: WIDTH].
- valid  output  DEPTH  bit i is set once entry i has been written since clear.
- all_valid  output  1  AND-reduction of valid.
- wr_drop  output  1  one-cycle pulse when a write is rejected.
- scan_start  input  1  request a minimum scan.
- scan_busy  output  1  high while the scanner is stepping through entries.
- scan_done  output  1  one-cycle pulse when results are updated.
- min_value  output  WIDTH  smallest valid value from the last scan.
- min_index  output  ADDR_W  index of min_value.
- none_valid  output  1  last scan found no valid entry.

Behaviour:
- Reset (clear high at a clk edge):
  - Zeroes every entry, valid, the scanner state, wr_drop, scan_done, min_index and none_valid.
  - Sets min_value to all-ones.
  - Has priority over every other input; clear mid-scan aborts the scan with no scan_done.
- Write path:
  - Zero latency in the address path: on a we edge, data is stored at addr and valid[addr] is set in the same edge, with no separate address-latch cycle.
  - q and valid reflect the write from the next cycle on.
- Rejected writes: wr_drop pulses for one cycle and storage is unchanged if either:
  - addr >= DEPTH, or
  - the write arrives while scan_busy = 1.
- Scanner FSM states: IDLE, SCAN, DONE.
  - IDLE: on scan_start go to SCAN; set idx = 0, running minimum = all-ones, found = 0.
  - SCAN: each cycle examine entry idx. If valid[idx] and (found = 0 or entry < running min), load running min and index and set found. Increment idx. Go to DONE after idx = DEPTH-1.
  - DONE: register min_value, min_index and none_valid = ~found; pulse scan_done; return to IDLE.
- Scanner timing and outputs:
  - scan_busy = 1 exactly in SCAN.
  - Timing: scan_start sampled at edge k; scan_done high in the cycle after edge k+DEPTH+1.
- Comparison rules:
  - Unsigned compare.
  - Ties go to the lowest index (strict less-than).
- Boundary conditions:
  - Result hold: min outputs hold until the next DONE.
  - No valid entries: none_valid = 1, min_value = all-ones, min_index = 0.
  - scan_start while in SCAN or DONE is ignored, not queued.
  - we and scan_start in the same IDLE cycle: the write is accepted and the scan sees the new value, because the entry is written before the scan reaches it.

Optional Feature:
- Macro: RAM_DIST_SCAN_MAX_EN.
- Defined: adds outputs max_value (WIDTH) and max_index (ADDR_W), computed in the same scan pass.
  - Ties go to the lowest index.
  - Reset value 0.
  - When no entry is valid, max_value = 0 and max_index = 0.
- Undefined: those ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package ram_dist_pkg holds:
  - the scanner state enum (IDLE, SCAN, DONE);
  - default constants RAM_DIST_WIDTH = 13 and RAM_DIST_DEPTH = 6.
- One natural sub-module, ram_dist_minscan: the FSM, index counter and running min/max.
  - It reads the flattened q and valid and drives the scan_* and min_* outputs.
- The top level keeps storage, valid bits and write gating.

Test Plan:
- Reset, then scan: check none_valid = 1, min_value = 0x1FFF, min_index = 0, valid = 0, scan_done pulse at start+7 cycles.
- Write 100, 40, 250, 40, 7, 900 to addresses 0..5: check all_valid = 1. Scan: check min_value = 7, min_index = 4. Rewrite addr 4 with 500 and rescan: check min_value = 40, min_index = 1 (tie rule).
- Write only addr 2 = 55, then scan: check min_value = 55, min_index = 2, none_valid = 0.
- Issue we to addr 3 on the cycle after scan_start: check wr_drop = 1 and entry 3 unchanged. Write to addr 6: check wr_drop = 1.
- Assert clear during SCAN: check no scan_done, all outputs at reset values, next scan completes normally.
- With RAM_DIST_SCAN_MAX_EN and the data of scenario 2: check max_value = 900, max_index = 5.
